// File: rtl/mmio_responder_if.sv
// Memory-control side bus of the MMIO responder: request, address/data, completion and hit.
interface mmio_if;
  logic        i_write_en;
  logic        i_read_en;
  logic [15:0] i_addr;
  logic [15:0] i_write_data;
  logic [15:0] o_read_data;
  logic        o_Ready_Bit;
  logic        o_Hit;

  modport slave (
    input  i_write_en, i_read_en, i_addr, i_write_data,
    output o_read_data, o_Ready_Bit, o_Hit
  );

  modport master (
    output i_write_en, i_read_en, i_addr, i_write_data,
    input  o_read_data, o_Ready_Bit, o_Hit
  );
endinterface

// File: rtl/mmio_responder.sv
// Memory-mapped keyboard/display/MCR responder with fixed access latency.
// state   | meaning
// IDLE    | waiting for a hit request
// WAIT    | latency countdown; access performed when counter is 0
// RDY     | o_Ready_Bit high for one cycle
// RELEASE | waiting for both enables low
module mmio_responder #(
  parameter int unsigned ACCESS_LAT = 1
) (
  input  logic       i_CLK,
  input  logic       i_Reset,
  mmio_if.slave      bus,
  input  logic       i_Key_Valid,
  input  logic [7:0] i_Key_Data,
  output logic       o_Disp_Valid,
  output logic [7:0] o_Disp_Data,
  input  logic       i_Disp_Ready,
  output logic       o_Int_Req,
  output logic       o_Key_Overrun,
  output logic       o_MCR_Run
);

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;
  localparam logic [3:0]  LAT_M1    = 4'(ACCESS_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDY, S_RELEASE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  wd_hi_q, wd_hi_d;
  logic [7:0]  wd_lo_q, wd_lo_d;
  logic        wr_q, wr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        kb_rdy_q, kb_rdy_d;
  logic        kb_ie_q, kb_ie_d;
  logic [7:0]  key_q, key_d;
  logic        ovr_q, ovr_d;
  logic        ds_rdy_q, ds_rdy_d;
  logic        ds_ie_q, ds_ie_d;
  logic        dv_q, dv_d;
  logic [7:0]  dd_q, dd_d;
  logic        run_q, run_d;

  logic        req;
  logic        do_acc;
  logic        kbdr_clr;
  logic [15:0] rd_val;

  assign req = bus.i_read_en | bus.i_write_en;

  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wd_hi_q  <= '0;
      wd_lo_q  <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      kb_rdy_q <= 1'b0;
      kb_ie_q  <= 1'b0;
      key_q    <= '0;
      ovr_q    <= 1'b0;
      ds_rdy_q <= 1'b1;
      ds_ie_q  <= 1'b0;
      dv_q     <= 1'b0;
      dd_q     <= '0;
      run_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wd_hi_q  <= wd_hi_d;
      wd_lo_q  <= wd_lo_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      kb_rdy_q <= kb_rdy_d;
      kb_ie_q  <= kb_ie_d;
      key_q    <= key_d;
      ovr_q    <= ovr_d;
      ds_rdy_q <= ds_rdy_d;
      ds_ie_q  <= ds_ie_d;
      dv_q     <= dv_d;
      dd_q     <= dd_d;
      run_q    <= run_d;
    end
  end

  always_comb begin
    rd_val = 16'h0000;
    case (addr_q)
      ADDR_KBSR: rd_val = {kb_rdy_q, kb_ie_q, 14'b0};
      ADDR_KBDR: rd_val = {8'h00, key_q};
      ADDR_DSR:  rd_val = {ds_rdy_q, ds_ie_q, 14'b0};
      ADDR_MCR:  rd_val = {run_q, 15'b0};
      default:   rd_val = 16'h0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wd_hi_d  = wd_hi_q;
    wd_lo_d  = wd_lo_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    kb_rdy_d = kb_rdy_q;
    kb_ie_d  = kb_ie_q;
    key_d    = key_q;
    ovr_d    = ovr_q;
    ds_rdy_d = ds_rdy_q;
    ds_ie_d  = ds_ie_q;
    dv_d     = dv_q;
    dd_d     = dd_q;
    run_d    = run_q;
    do_acc   = 1'b0;
    kbdr_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req && bus.o_Hit) begin
          addr_d  = bus.i_addr;
          wd_hi_d = bus.i_write_data[15:14];
          wd_lo_d = bus.i_write_data[7:0];
          wr_d    = bus.i_write_en;
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_acc  = 1'b1;
          state_d = S_RDY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RDY:     state_d = S_RELEASE;
      S_RELEASE: if (!req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (do_acc) begin
      if (wr_q) begin
        case (addr_q)
          ADDR_KBSR: kb_ie_d = wd_hi_q[0];
          ADDR_DSR:  ds_ie_d = wd_hi_q[0];
          ADDR_DDR: begin
            if (ds_rdy_q) begin
              dd_d     = wd_lo_q;
              ds_rdy_d = 1'b0;
              dv_d     = 1'b1;
            end
          end
          ADDR_MCR:  run_d = wd_hi_q[1];
          default:   ;
        endcase
      end else begin
        rdata_d  = rd_val;
        kbdr_clr = (addr_q == ADDR_KBDR);
      end
    end

    // A key arriving on the same edge as a KBDR read refills the buffer instead of overrunning.
    if (i_Key_Valid) begin
      if (!kb_rdy_q || kbdr_clr) begin
        key_d    = i_Key_Data;
        kb_rdy_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (kbdr_clr) begin
      kb_rdy_d = 1'b0;
    end

    if (dv_q && i_Disp_Ready) begin
      dv_d     = 1'b0;
      ds_rdy_d = 1'b1;
    end
  end

  assign bus.o_Hit       = (bus.i_addr[15:9] == 7'h7F);
  assign bus.o_Ready_Bit = (state_q == S_RDY);
  assign bus.o_read_data = rdata_q;
  assign o_Disp_Valid    = dv_q;
  assign o_Disp_Data     = dd_q;
  assign o_Key_Overrun   = ovr_q;
  assign o_MCR_Run       = run_q;
  assign o_Int_Req       = (kb_rdy_q & kb_ie_q) | (ds_rdy_q & ds_ie_q);

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: two instances (latency 1 and 4) on shared stimulus,
// compared every cycle against a transaction-timed register model.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [15:0] addr = 16'h0000, wdata = 16'h0000;
  logic        kv = 1'b0;
  logic [7:0]  kd = 8'h00;
  logic        dready = 1'b0;
  bit          rnd_on = 1'b0;

  always #5 clk = ~clk;

  mmio_if bus0 ();
  mmio_if bus1 ();

  assign bus0.i_read_en = rd_en;  assign bus1.i_read_en = rd_en;
  assign bus0.i_write_en = wr_en; assign bus1.i_write_en = wr_en;
  assign bus0.i_addr = addr;      assign bus1.i_addr = addr;
  assign bus0.i_write_data = wdata; assign bus1.i_write_data = wdata;

  logic       dvalid [2];
  logic [7:0] ddata  [2];
  logic       intr   [2];
  logic       ovr    [2];
  logic       run    [2];
  logic       rdy    [2];
  logic       hit    [2];
  logic [15:0] rdata [2];

  assign rdy[0] = bus0.o_Ready_Bit; assign rdy[1] = bus1.o_Ready_Bit;
  assign hit[0] = bus0.o_Hit;       assign hit[1] = bus1.o_Hit;
  assign rdata[0] = bus0.o_read_data; assign rdata[1] = bus1.o_read_data;

  mmio_responder #(.ACCESS_LAT(1)) dut0 (
    .i_CLK(clk), .i_Reset(rst), .bus(bus0),
    .i_Key_Valid(kv), .i_Key_Data(kd),
    .o_Disp_Valid(dvalid[0]), .o_Disp_Data(ddata[0]), .i_Disp_Ready(dready),
    .o_Int_Req(intr[0]), .o_Key_Overrun(ovr[0]), .o_MCR_Run(run[0])
  );

  mmio_responder #(.ACCESS_LAT(4)) dut1 (
    .i_CLK(clk), .i_Reset(rst), .bus(bus1),
    .i_Key_Valid(kv), .i_Key_Data(kd),
    .o_Disp_Valid(dvalid[1]), .o_Disp_Data(ddata[1]), .i_Disp_Ready(dready),
    .o_Int_Req(intr[1]), .o_Key_Overrun(ovr[1]), .o_MCR_Run(run[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s dut%0d at t=%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          model_ok = 1'b0;
  bit          m_busy [2];
  int          m_at   [2];
  logic [15:0] m_a    [2];
  logic [15:0] m_d    [2];
  bit          m_w    [2];
  bit          m_rdy  [2];
  logic [15:0] m_rd   [2];
  bit          m_kr [2], m_kie [2], m_ovr [2];
  logic [7:0]  m_key [2];
  bit          m_dr [2], m_die [2], m_dv [2];
  logic [7:0]  m_dd [2];
  bit          m_run [2];
  bit          t_acc, t_clr, t_kr, t_dr, t_dv;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_ok = 1'b1;
        m_busy[d] = 0; m_at[d] = 0; m_rdy[d] = 0; m_rd[d] = 16'h0000;
        m_kr[d] = 0; m_kie[d] = 0; m_key[d] = 8'h00; m_ovr[d] = 0;
        m_dr[d] = 1; m_die[d] = 0; m_dv[d] = 0; m_dd[d] = 8'h00; m_run[d] = 1;
      end else begin
        t_acc = 0; t_clr = 0;
        t_kr = m_kr[d]; t_dr = m_dr[d]; t_dv = m_dv[d];
        m_rdy[d] = 0;
        if (!m_busy[d]) begin
          if ((rd_en || wr_en) && addr >= 16'hFE00) begin
            m_busy[d] = 1; m_at[d] = cyc + lat_of(d);
            m_a[d] = addr; m_d[d] = wdata; m_w[d] = wr_en;
          end
        end else if (cyc == m_at[d]) begin
          t_acc = 1; m_rdy[d] = 1;
        end else if (cyc >= m_at[d] + 2 && !rd_en && !wr_en) begin
          m_busy[d] = 0;
        end
        if (t_acc && !m_w[d]) begin
          if (m_a[d] == 16'hFE00)      m_rd[d] = t_kr ? 16'h8000 : 16'h0000;
          else if (m_a[d] == 16'hFE02) m_rd[d] = {8'h00, m_key[d]};
          else if (m_a[d] == 16'hFE04) m_rd[d] = t_dr ? 16'h8000 : 16'h0000;
          else if (m_a[d] == 16'hFFFE) m_rd[d] = m_run[d] ? 16'h8000 : 16'h0000;
          else                         m_rd[d] = 16'h0000;
          if (m_a[d] == 16'hFE00 && m_kie[d]) m_rd[d] = m_rd[d] + 16'h4000;
          if (m_a[d] == 16'hFE04 && m_die[d]) m_rd[d] = m_rd[d] + 16'h4000;
          t_clr = (m_a[d] == 16'hFE02);
        end
        if (t_acc && m_w[d]) begin
          if (m_a[d] == 16'hFE00) m_kie[d] = m_d[d][14];
          if (m_a[d] == 16'hFE04) m_die[d] = m_d[d][14];
          if (m_a[d] == 16'hFFFE) m_run[d] = m_d[d][15];
          if (m_a[d] == 16'hFE06 && t_dr) begin
            m_dd[d] = m_d[d][7:0]; m_dr[d] = 0; m_dv[d] = 1;
          end
        end
        if (kv) begin
          if (t_kr && !t_clr) m_ovr[d] = 1;
          else begin m_key[d] = kd; m_kr[d] = 1; end
        end else if (t_clr) begin
          m_kr[d] = 0;
        end
        if (t_dv && dready) begin
          m_dv[d] = 0; m_dr[d] = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int rcnt [2] = '{0, 0};
  int rcyc [2] = '{0, 0};

  always @(negedge clk) begin
    if (model_ok) begin
      for (int d = 0; d < 2; d++) begin
        if (rdy[d] === 1'b1) begin rcnt[d]++; rcyc[d] = cyc; end
        chk("ready",  d, 16'(rdy[d]),    16'(m_rdy[d]));
        chk("rdata",  d, rdata[d],       m_rd[d]);
        chk("hit",    d, 16'(hit[d]),    16'(addr >= 16'hFE00));
        chk("dvalid", d, 16'(dvalid[d]), 16'(m_dv[d]));
        chk("ddata",  d, 16'(ddata[d]),  16'(m_dd[d]));
        chk("intreq", d, 16'(intr[d]),   16'((m_kr[d] && m_kie[d]) || (m_dr[d] && m_die[d])));
        chk("overrun",d, 16'(ovr[d]),    16'(m_ovr[d]));
        chk("mcr_run",d, 16'(run[d]),    16'(m_run[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req(input bit r, input bit w, input logic [15:0] a, input logic [15:0] dat,
                     input int hold, output int acc);
    rd_en = r; wr_en = w; addr = a; wdata = dat;
    acc = cyc + 1;
    repeat (hold) step();
    rd_en = 0; wr_en = 0;
    repeat ((hold < 8) ? (9 - hold) : 2) step();
  endtask

  task automatic xact(input bit r, input bit w, input logic [15:0] a, input logic [15:0] dat,
                      input int hold, input bit pulse);
    int c0, c1, acc;
    c0 = rcnt[0]; c1 = rcnt[1];
    req(r, w, a, dat, hold, acc);
    chk("pulses", 0, 16'(rcnt[0] - c0), 16'(pulse));
    chk("pulses", 1, 16'(rcnt[1] - c1), 16'(pulse));
    if (pulse) begin
      chk("latency", 0, 16'(rcyc[0] - acc), 16'd1);
      chk("latency", 1, 16'(rcyc[1] - acc), 16'd4);
    end
  endtask

  task automatic key(input logic [7:0] b);
    kv = 1; kd = b; step();
    kv = 0; step();
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd_on) begin
      dready = ($urandom_range(0, 3) == 0);
      kv     = ($urandom_range(0, 9) == 0);
      kd     = 8'($urandom);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] rlist [8] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06,
                             16'hFFFE, 16'hFE10, 16'h3000, 16'hFE00};

  initial begin
    int c1, acc, sel, dir;
    logic [15:0] ra;

    rst = 1; repeat (3) step(); rst = 0; step();
    chk("rst_rdata",  0, rdata[0], 16'h0000);
    chk("rst_run",    0, 16'(run[0]), 16'd1);
    chk("rst_dvalid", 0, 16'(dvalid[0]), 16'd0);
    chk("rst_int",    1, 16'(intr[1]), 16'd0);

    // keyboard byte then status/data reads
    key(8'h41);
    xact(1, 0, 16'hFE00, 16'h0, 1, 1); chk("kbsr_full", 0, rdata[0], 16'h8000);
    xact(1, 0, 16'hFE02, 16'h0, 1, 1); chk("kbdr", 0, rdata[0], 16'h0041);
    chk("kbdr", 1, rdata[1], 16'h0041);
    xact(1, 0, 16'hFE00, 16'h0, 1, 1); chk("kbsr_empty", 0, rdata[0], 16'h0000);

    // display write and sink handshake
    xact(0, 1, 16'hFE06, 16'h0058, 1, 1);
    chk("disp_valid", 0, 16'(dvalid[0]), 16'd1);
    chk("disp_data",  0, 16'(ddata[0]), 16'h0058);
    xact(1, 0, 16'hFE04, 16'h0, 1, 1); chk("dsr_busy", 0, rdata[0], 16'h0000);
    repeat (5) step();
    chk("disp_hold", 1, 16'(dvalid[1]), 16'd1);
    dready = 1; step(); dready = 0; step();
    chk("disp_done", 0, 16'(dvalid[0]), 16'd0);
    xact(1, 0, 16'hFE04, 16'h0, 1, 1); chk("dsr_ready", 0, rdata[0], 16'h8000);

    // overrun
    key(8'h31); key(8'h32);
    chk("overrun", 0, 16'(ovr[0]), 16'd1);
    xact(1, 0, 16'hFE02, 16'h0, 1, 1); chk("kbdr_first", 0, rdata[0], 16'h0031);

    // held read, MCR
    xact(1, 0, 16'hFFFE, 16'h0, 10, 1); chk("mcr_read", 1, rdata[1], 16'h8000);
    xact(0, 1, 16'hFFFE, 16'h0000, 1, 1);
    chk("mcr_stop", 0, 16'(run[0]), 16'd0);
    chk("mcr_stop", 1, 16'(run[1]), 16'd0);

    // interrupt, unmapped, non-hit
    xact(0, 1, 16'hFE00, 16'h4000, 1, 1);
    key(8'h0A);
    chk("int_on", 0, 16'(intr[0]), 16'd1);
    xact(1, 0, 16'hFE02, 16'h0, 1, 1);
    chk("kbdr_0a", 0, rdata[0], 16'h000A);
    chk("int_off", 0, 16'(intr[0]), 16'd0);
    xact(1, 0, 16'hFE10, 16'h0, 1, 1); chk("unmapped", 0, rdata[0], 16'h0000);
    addr = 16'h3000; #1;
    chk("nohit", 0, 16'(hit[0]), 16'd0);
    xact(1, 0, 16'h3000, 16'h0, 2, 0);

    // reset in the middle of a latency-4 DDR write
    c1 = rcnt[1];
    rd_en = 0; wr_en = 1; addr = 16'hFE06; wdata = 16'h0033;
    step(); step();
    rst = 1; wr_en = 0; step();
    rst = 0; repeat (7) step();
    chk("abort_pulses", 1, 16'(rcnt[1] - c1), 16'd0);
    chk("abort_dvalid", 1, 16'(dvalid[1]), 16'd0);
    chk("abort_dvalid", 0, 16'(dvalid[0]), 16'd0);
    xact(1, 0, 16'hFE04, 16'h0, 1, 1); chk("abort_dsr", 1, rdata[1], 16'h8000);

    // randomized traffic
    rnd_on = 1;
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 7);
      ra = rlist[sel];
      if (sel == 7) ra = 16'hFE00 | 16'($urandom_range(0, 511));
      if ($urandom_range(0, 9) == 0) ra = 16'($urandom);
      dir = $urandom_range(0, 2);
      req(dir != 1, dir != 0, ra, 16'($urandom), $urandom_range(1, 10), acc);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1; step(); rst = 0;
      end
      repeat ($urandom_range(0, 3)) step();
    end
    rnd_on = 0;
    step(); kv = 0; dready = 0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
